posit_div_issue: RTL and testbench

- Initiator/sequencer for the iterative posit divider's start/done handshake. That handshake is the one the fixed-latency retimed wrapper leaves unused.
- Accepts divide requests on a valid/ready port and launches one divide at a time with a single-cycle start pulse. Waits for done, or a timeout, and queues tagged results in a small response FIFO.
- Sits between the issue/dispatch logic and the divider core, so the core can run with variable latency.

---
 rtl/posit_div_issue.sv | 207 ++++++++++++++++++++
 tb/tb_posit_div_issue.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_div_issue.sv
// rtl/posit_div_issue.sv - start/done sequencer and tagged response FIFO for the iterative posit divider
//
// Accepts one divide request at a time, launches the divider core with a
// single-cycle start pulse, waits for done (or gives up after TIMEOUT wait
// cycles) and queues the tagged result in a small first-word-fall-through FIFO.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ce             clock enable for the sequencer and its wait counter
//   req_*          request port (valid/ready), dividend, divisor, tag
//   div_start      one-cycle start pulse to the divider core
//   div_a, div_b   operands held stable for the divider
//   div_done       divider completion, with div_o / div_zero / div_inf
//   rsp_*          response FIFO head (valid/ready), quotient, flags, tag, timeout
//   busy           a divide is in flight
module posit_div_issue #(
    parameter int PSTWID  = 32,
    parameter int TAGW    = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [PSTWID-1:0] req_a,
    input  logic [PSTWID-1:0] req_b,
    input  logic [TAGW-1:0]   req_tag,
    output logic              div_start,
    output logic [PSTWID-1:0] div_a,
    output logic [PSTWID-1:0] div_b,
    input  logic              div_done,
    input  logic [PSTWID-1:0] div_o,
    input  logic              div_zero,
    input  logic              div_inf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PSTWID-1:0] rsp_o,
    output logic              rsp_zero,
    output logic              rsp_inf,
    output logic [TAGW-1:0]   rsp_tag,
    output logic              rsp_timeout,
    output logic              busy
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNW = AW + 1;
    // The wait counter only has to reach TIMEOUT-1.
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PSTWID-1:0] NAR       = {1'b1, {(PSTWID-1){1'b0}}};
    localparam logic [CNW-1:0]    FULL_CNT  = CNW'(DEPTH);
    localparam logic [TW-1:0]     LAST_WAIT = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t state, state_nxt;

    // In-flight operation and its captured result
    logic [TAGW-1:0]   lat_tag;
    logic [TW-1:0]     wait_cnt;
    logic [PSTWID-1:0] res_o;
    logic              res_zero;
    logic              res_inf;
    logic              res_to;

    // Response FIFO storage
    logic [PSTWID-1:0] fifo_o    [DEPTH];
    logic              fifo_zero [DEPTH];
    logic              fifo_inf  [DEPTH];
    logic [TAGW-1:0]   fifo_tag  [DEPTH];
    logic              fifo_to   [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNW-1:0]    fifo_cnt;

    logic accept;
    logic push;
    logic pop;
    logic timeout_hit;

    // Handshake decode. req_ready and div_start are held low while rst is
    // asserted so nothing is accepted or launched during reset.
    always_comb begin
        req_ready   = !rst && ce && (state == S_IDLE) && (fifo_cnt != FULL_CNT);
        accept      = req_ready && req_valid;
        div_start   = !rst && ce && (state == S_START);
        push        = ce && (state == S_PUSH);
        pop         = rsp_ready && (fifo_cnt != '0);
        timeout_hit = (wait_cnt == LAST_WAIT);
    end

    assign busy = (state != S_IDLE);

    // Next-state logic; nothing moves while ce is low.
    always_comb begin
        state_nxt = state;
        if (ce) begin
            case (state)
                S_IDLE:  if (accept) state_nxt = S_START;
                S_START: state_nxt = S_WAIT;
                S_WAIT:  if (div_done || timeout_hit) state_nxt = S_PUSH;
                S_PUSH:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, wait counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_a    <= '0;
            div_b    <= '0;
            lat_tag  <= '0;
            wait_cnt <= '0;
            res_o    <= '0;
            res_zero <= 1'b0;
            res_inf  <= 1'b0;
            res_to   <= 1'b0;
        end else begin
            if (accept) begin
                div_a   <= req_a;
                div_b   <= req_b;
                lat_tag <= req_tag;
            end
            if (ce) begin
                case (state)
                    S_START: wait_cnt <= '0;
                    S_WAIT: begin
                        // A real completion wins over a timeout in the same cycle.
                        if (div_done) begin
                            res_o    <= div_o;
                            res_zero <= div_zero;
                            res_inf  <= div_inf;
                            res_to   <= 1'b0;
                        end else if (timeout_hit) begin
                            res_o    <= NAR;
                            res_zero <= 1'b0;
                            res_inf  <= 1'b1;
                            res_to   <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Response FIFO. Storage is cleared on reset so the head never shows X.
    // A push cannot meet a full FIFO: a request is only accepted with a free
    // slot and only one divide is ever in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_o[i]    <= '0;
                fifo_zero[i] <= 1'b0;
                fifo_inf[i]  <= 1'b0;
                fifo_tag[i]  <= '0;
                fifo_to[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_o[wr_ptr]    <= res_o;
                fifo_zero[wr_ptr] <= res_zero;
                fifo_inf[wr_ptr]  <= res_inf;
                fifo_tag[wr_ptr]  <= lat_tag;
                fifo_to[wr_ptr]   <= res_to;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNW'(1);
                default: ;
            endcase
        end
    end

    assign rsp_valid   = (fifo_cnt != '0);
    assign rsp_o       = fifo_o[rd_ptr];
    assign rsp_zero    = fifo_zero[rd_ptr];
    assign rsp_inf     = fifo_inf[rd_ptr];
    assign rsp_tag     = fifo_tag[rd_ptr];
    assign rsp_timeout = fifo_to[rd_ptr];

endmodule

// File: tb/tb_posit_div_issue.sv
// tb/tb_posit_div_issue.sv - self-checking bench for posit_div_issue
module tb_posit_div_issue;

    localparam int PW      = 32;
    localparam int TW      = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          req_valid;
    logic          req_ready;
    logic [PW-1:0] req_a;
    logic [PW-1:0] req_b;
    logic [TW-1:0] req_tag;
    logic          div_start;
    logic [PW-1:0] div_a;
    logic [PW-1:0] div_b;
    logic          div_done;
    logic [PW-1:0] div_o;
    logic          div_zero;
    logic          div_inf;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [PW-1:0] rsp_o;
    logic          rsp_zero;
    logic          rsp_inf;
    logic [TW-1:0] rsp_tag;
    logic          rsp_timeout;
    logic          busy;

    posit_div_issue #(
        .PSTWID (PW),
        .TAGW   (TW),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_o      (div_o),
        .div_zero   (div_zero),
        .div_inf    (div_inf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_o      (rsp_o),
        .rsp_zero   (rsp_zero),
        .rsp_inf    (rsp_inf),
        .rsp_tag    (rsp_tag),
        .rsp_timeout(rsp_timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit cmp_en = 0;
    bit jitter = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- divider responder ----------------
    int done_delay  = 1;   // cycles from start to done; negative = never
    bit resp_pending = 0;
    int start_cyc   = 0;
    bit force_done  = 0;

    always @(negedge clk) begin
        if (div_start) begin
            resp_pending = 1;
            start_cyc    = cyc;
        end
    end

    always @(posedge clk) begin
        #1;
        div_done = 1'b0;
        div_o    = $urandom;
        div_zero = 1'($urandom);
        div_inf  = 1'($urandom);
        if (force_done || (resp_pending && done_delay >= 0 && cyc >= start_cyc + done_delay)) begin
            div_done     = 1'b1;
            resp_pending = 0;
            force_done   = 0;
            if (div_a == 32'h4000_0000 && div_b == 32'h4800_0000) div_o = 32'h3800_0000;
        end
        if (jitter) begin
            ce        = ($urandom_range(9) != 0);
            rsp_ready = 1'($urandom);
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic [PW-1:0] o;
        logic          z;
        logic          i;
        logic [TW-1:0] tag;
        logic          to;
    } ent_t;

    ent_t          m_q[$];
    ent_t          m_res;
    bit            m_active   = 0;   // an operation has been accepted and not yet queued
    bit            m_started  = 0;   // its start pulse has been issued
    bit            m_have_res = 0;   // its result is known and is queued on the next enabled edge
    int            m_waits    = 0;   // enabled wait cycles spent without a completion
    logic [PW-1:0] m_a, m_b;
    logic [TW-1:0] m_tag;

    always @(posedge clk) begin : model
        bit rdy;
        rdy = ce && !m_active && (m_q.size() < DEPTH);
        if (rst) begin
            m_q.delete();
            m_active   = 0;
            m_started  = 0;
            m_have_res = 0;
            m_waits    = 0;
        end else begin
            if (rsp_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (ce) begin
                if (m_have_res) begin
                    m_q.push_back(m_res);
                    m_active   = 0;
                    m_have_res = 0;
                end else if (m_active && !m_started) begin
                    m_started = 1;
                    m_waits   = 0;
                end else if (m_active) begin
                    if (div_done) begin
                        m_res.o = div_o; m_res.z = div_zero; m_res.i = div_inf;
                        m_res.tag = m_tag; m_res.to = 1'b0;
                        m_have_res = 1;
                    end else if (m_waits == TIMEOUT - 1) begin
                        m_res.o = 32'h8000_0000; m_res.z = 1'b0; m_res.i = 1'b1;
                        m_res.tag = m_tag; m_res.to = 1'b1;
                        m_have_res = 1;
                    end else begin
                        m_waits++;
                    end
                end else if (req_valid && rdy) begin
                    m_active  = 1;
                    m_started = 0;
                    m_a       = req_a;
                    m_b       = req_b;
                    m_tag     = req_tag;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [TW-1:0] got_q[$];
    logic [TW-1:0] iss_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_ready", req_ready, !rst && ce && !m_active && (m_q.size() < DEPTH));
            chk("div_start", div_start, !rst && ce && m_active && !m_started);
            chk("busy", busy, m_active);
            chk("rsp_valid", rsp_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("rsp_o", rsp_o, m_q[0].o);
                chk("rsp_zero", rsp_zero, m_q[0].z);
                chk("rsp_inf", rsp_inf, m_q[0].i);
                chk("rsp_tag", rsp_tag, m_q[0].tag);
                chk("rsp_timeout", rsp_timeout, m_q[0].to);
            end
            if (m_active) begin
                chk("div_a", div_a, m_a);
                chk("div_b", div_b, m_b);
            end
            if (rsp_valid && rsp_ready && !rst) got_q.push_back(rsp_tag);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_neg(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
    endtask

    task automatic do_req(input logic [PW-1:0] a, input logic [PW-1:0] b,
                          input logic [TW-1:0] tag, output int t);
        bit acc;
        acc = 0;
        t   = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_a = a; req_b = b; req_tag = tag;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1;
                t   = cyc;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_tag = 4'($urandom);
        chk("req_accepted", acc, 1);
        if (acc) iss_q.push_back(tag);
    endtask

    task automatic drain();
        bit empty;
        empty = 0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 600 && !empty; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) empty = 1;
        end
        chk("drain_done", empty, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic cmp_tags();
        chk("tag_count", got_q.size(), iss_q.size());
        for (int i = 0; i < got_q.size() && i < iss_q.size(); i++) chk("tag_order", got_q[i], iss_q[i]);
        got_q.delete();
        iss_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t;
        bit acc;
        rst = 1'b1; ce = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_div_a", div_a, 0);
        chk("reset_rsp_o", rsp_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        // Basic divide: 1.0 / 2.0, done five cycles after start
        done_delay = 5;
        do_req(32'h4000_0000, 32'h4800_0000, 4'd3, t);
        wait_neg(t + 1); chk("basic_start_T+1", div_start, 1);
        wait_neg(t + 2); chk("basic_start_T+2", div_start, 0);
        wait_neg(t + 7); chk("basic_valid_T+7", rsp_valid, 0);
        wait_neg(t + 8);
        chk("basic_valid_T+8", rsp_valid, 1);
        chk("basic_o", rsp_o, 32'h3800_0000);
        chk("basic_tag", rsp_tag, 3);
        chk("basic_timeout", rsp_timeout, 0);
        drain();
        cmp_tags();

        // Timeout: divider never completes; a late done must be ignored
        done_delay = -1;
        do_req(32'h1234_5678, 32'h0bad_cafe, 4'd9, t);
        wait_neg(t + 2 + TIMEOUT); chk("to_valid_early", rsp_valid, 0);
        wait_neg(t + 3 + TIMEOUT);
        chk("to_valid", rsp_valid, 1);
        chk("to_o", rsp_o, 32'h8000_0000);
        chk("to_inf", rsp_inf, 1);
        chk("to_zero", rsp_zero, 0);
        chk("to_flag", rsp_timeout, 1);
        chk("to_tag", rsp_tag, 9);
        force_done = 1;
        repeat (3) @(negedge clk);
        drain();
        chk("to_stray_busy", busy, 0);
        cmp_tags();

        // Backpressure: four results fill the FIFO, the fifth waits for a pop
        done_delay = 1;
        for (int i = 1; i <= 4; i++) do_req($urandom, $urandom, 4'(i), t);
        repeat (4) @(posedge clk);
        #1;
        req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_tag = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready_low", req_ready, 0);
            chk("bp_idle", busy, 0);
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1;
        end
        chk("bp_fifth_accepted", acc, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        iss_q.push_back(4'd5);
        drain();
        cmp_tags();

        // Simultaneous push and pop with a consumer that is always ready
        rsp_ready = 1'b1;
        done_delay = 1;
        for (int i = 0; i < 8; i++) do_req($urandom, $urandom, 4'(i + 7), t);
        drain();
        cmp_tags();

        // ce freeze during WAIT; FIFO still pops while ce is low
        done_delay = 1;
        do_req($urandom, $urandom, 4'd6, t);
        done_delay = 13;
        do_req($urandom, $urandom, 4'd7, t);
        wait_neg(t + 2);
        @(posedge clk); #1; ce = 1'b0;
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        wait_neg(t + 6);
        chk("ce_pop_while_frozen", rsp_valid, 0);
        chk("ce_busy_frozen", busy, 1);
        wait_neg(t + 12);
        chk("ce_no_spurious_timeout", rsp_valid, 0);
        @(posedge clk); #1; ce = 1'b1;
        wait_neg(t + 16);
        chk("ce_result_valid", rsp_valid, 1);
        chk("ce_result_tag", rsp_tag, 7);
        chk("ce_result_timeout", rsp_timeout, 0);
        drain();
        cmp_tags();

        // Reset in the middle of WAIT, then a stale done
        done_delay = 1;
        do_req($urandom, $urandom, 4'd8, t);
        done_delay = -1;
        do_req($urandom, $urandom, 4'd9, t);
        wait_neg(t + 3);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_a", div_a, 0);
        chk("rst_div_b", div_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_o", rsp_o, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_flags", {rsp_zero, rsp_inf, rsp_timeout}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); force_done = 1;
        wait_neg(t + 10);
        chk("rst_stale_done_valid", rsp_valid, 0);
        chk("rst_stale_done_busy", busy, 0);
        got_q.delete();
        iss_q.delete();

        // Randomized traffic with ce and consumer jitter
        jitter = 1;
        for (int n = 0; n < 40; n++) begin
            done_delay = $urandom_range(8);
            repeat ($urandom_range(2)) @(posedge clk);
            do_req($urandom, ($urandom_range(7) == 0) ? 32'h0 : $urandom, 4'($urandom), t);
        end
        jitter = 0;
        @(posedge clk); #1; ce = 1'b1;
        drain();
        cmp_tags();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        n_bad++;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to end", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
